// File: rtl/qspi_ctrl_pkg.sv
// Shared definitions for the QSPI controller slice.
// Holds the command-engine state encoding used by ce.
package qspi_ctrl_pkg;

    // Command engine states, 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        LAUNCH = 2'b01,
        WAIT   = 2'b10,
        DONE   = 2'b11
    } ce_state_t;

endpackage : qspi_ctrl_pkg

// File: rtl/ce.sv
// Command engine between CSR, QSPI protocol FSM and DMA engine.
// A CSR trigger launches a QSPI transaction (and optionally a DMA transfer),
// acknowledges the trigger with clear_cmd and reports completion of both
// sides with a single cmd_done pulse.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   cmd_trigger CSR command request, sampled only in IDLE
//   dma_en      command uses DMA, sampled at trigger acceptance
//   clear_cmd   1-cycle pulse: CSR clears its trigger bit
//   cmd_done    1-cycle pulse: command fully complete
//   busy        high while a command is in progress
//   dma_done    DMA completion pulse
//   dma_start   1-cycle DMA launch pulse
//   done_qspi   QSPI FSM completion pulse
//   start_qspi  1-cycle QSPI launch pulse
module ce
    import qspi_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic cmd_trigger,
    input  logic dma_en,
    output logic clear_cmd,
    output logic cmd_done,
    output logic busy,
    input  logic dma_done,
    output logic dma_start,
    input  logic done_qspi,
    output logic start_qspi
);

    ce_state_t state_r;
    ce_state_t next_state_s;

    logic dma_en_q_r;
    logic qspi_seen_r;
    logic dma_seen_r;

    logic next_dma_en_q_s;
    logic next_qspi_seen_s;
    logic next_dma_seen_s;

    logic complete_s;

    logic clear_cmd_r;
    logic cmd_done_r;
    logic busy_r;
    logic dma_start_r;
    logic start_qspi_r;

    // Next-state and sticky-flag logic.
    always_comb begin
        next_state_s     = state_r;
        next_dma_en_q_s  = dma_en_q_r;
        next_qspi_seen_s = qspi_seen_r;
        next_dma_seen_s  = dma_seen_r;
        // Current-cycle done inputs count towards completion.
        complete_s = (qspi_seen_r | done_qspi) &
                     (~dma_en_q_r | dma_seen_r | dma_done);

        case (state_r)
            IDLE: begin
                if (cmd_trigger) begin
                    next_state_s     = LAUNCH;
                    next_dma_en_q_s  = dma_en;
                    next_qspi_seen_s = 1'b0;
                    next_dma_seen_s  = 1'b0;
                end else begin
                    next_state_s = IDLE;
                end
            end
            LAUNCH: begin
                // Done inputs are deliberately not sampled here.
                next_state_s = WAIT;
            end
            WAIT: begin
                next_qspi_seen_s = qspi_seen_r | done_qspi;
                // A DMA completion is meaningless for a non-DMA command.
                next_dma_seen_s  = dma_seen_r | (dma_done & dma_en_q_r);
                if (complete_s) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = WAIT;
                end
            end
            DONE: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State, flag and registered Moore-output update.
    // Outputs are decoded from the next state so they line up with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            dma_en_q_r   <= 1'b0;
            qspi_seen_r  <= 1'b0;
            dma_seen_r   <= 1'b0;
            clear_cmd_r  <= 1'b0;
            cmd_done_r   <= 1'b0;
            busy_r       <= 1'b0;
            dma_start_r  <= 1'b0;
            start_qspi_r <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            dma_en_q_r   <= next_dma_en_q_s;
            qspi_seen_r  <= next_qspi_seen_s;
            dma_seen_r   <= next_dma_seen_s;
            clear_cmd_r  <= (next_state_s == LAUNCH);
            start_qspi_r <= (next_state_s == LAUNCH);
            dma_start_r  <= (next_state_s == LAUNCH) & next_dma_en_q_s;
            cmd_done_r   <= (next_state_s == DONE);
            busy_r       <= (next_state_s != IDLE);
        end
    end

    assign clear_cmd  = clear_cmd_r;
    assign cmd_done   = cmd_done_r;
    assign busy       = busy_r;
    assign dma_start  = dma_start_r;
    assign start_qspi = start_qspi_r;

endmodule : ce

// File: tb/tb_ce.sv
// Directed self-checking bench for the command engine ce.
module tb_ce;

    logic clk;
    logic rst;
    logic cmd_trigger;
    logic dma_en;
    logic clear_cmd;
    logic cmd_done;
    logic busy;
    logic dma_done;
    logic dma_start;
    logic done_qspi;
    logic start_qspi;

    int tests_run;
    int tests_failed;
    int done_cnt;
    int clear_cnt;
    int start_cnt;
    int base_done;
    int base_clear;
    int base_start;

    ce dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_trigger(cmd_trigger),
        .dma_en     (dma_en),
        .clear_cmd  (clear_cmd),
        .cmd_done   (cmd_done),
        .busy       (busy),
        .dma_done   (dma_done),
        .dma_start  (dma_start),
        .done_qspi  (done_qspi),
        .start_qspi (start_qspi)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count output pulses mid-cycle, away from the active edge.
    initial begin
        done_cnt  = 0;
        clear_cnt = 0;
        start_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst && cmd_done === 1'b1)   done_cnt++;
            if (!rst && clear_cmd === 1'b1)  clear_cnt++;
            if (!rst && start_qspi === 1'b1) start_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs set afterwards are sampled at the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic logic [4:0] outs();
        return {start_qspi, clear_cmd, dma_start, cmd_done, busy};
    endfunction

    task automatic snap();
        base_done  = done_cnt;
        base_clear = clear_cnt;
        base_start = start_cnt;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        cmd_trigger  = 1'b0;
        dma_en       = 1'b0;
        dma_done     = 1'b0;
        done_qspi    = 1'b0;

        // Reset held for 10 cycles with random inputs.
        for (int i = 0; i < 10; i++) begin
            cmd_trigger = 1'($urandom_range(1, 0));
            dma_en      = 1'($urandom_range(1, 0));
            dma_done    = 1'($urandom_range(1, 0));
            done_qspi   = 1'($urandom_range(1, 0));
            tick();
            check("reset_outs", 32'(outs()), 32'h0);
        end
        cmd_trigger = 1'b0;
        dma_en      = 1'b0;
        dma_done    = 1'b0;
        done_qspi   = 1'b0;
        rst         = 1'b0;
        ticks(3);
        check("post_reset_outs", 32'(outs()), 32'h0);

        // No-DMA command.
        snap();
        cmd_trigger = 1'b1;
        tick();
        cmd_trigger = 1'b0;
        // {start_qspi, clear_cmd, dma_start, cmd_done, busy}
        check("nodma_launch", 32'(outs()), 32'b11001);
        tick();
        check("nodma_wait", 32'(outs()), 32'b00001);
        ticks(4);
        done_qspi = 1'b1;
        tick();
        done_qspi = 1'b0;
        check("nodma_done", 32'(outs()), 32'b00011);
        tick();
        check("nodma_idle", 32'(outs()), 32'b00000);
        check("nodma_done_cnt", 32'(done_cnt - base_done), 32'd1);
        check("nodma_clear_cnt", 32'(clear_cnt - base_clear), 32'd1);

        // DMA command, QSPI finishes first.
        snap();
        dma_en      = 1'b1;
        cmd_trigger = 1'b1;
        tick();
        cmd_trigger = 1'b0;
        check("dmaq_launch", 32'(outs()), 32'b11101);
        tick();
        check("dmaq_wait", 32'(outs()), 32'b00001);
        done_qspi = 1'b1;
        tick();
        done_qspi = 1'b0;
        ticks(10);
        check("dmaq_half_no_done", 32'(done_cnt - base_done), 32'd0);
        check("dmaq_half_busy", 32'(busy), 32'd1);
        dma_done = 1'b1;
        tick();
        dma_done = 1'b0;
        check("dmaq_done", 32'(outs()), 32'b00011);
        tick();
        check("dmaq_idle", 32'(outs()), 32'b00000);

        // DMA command, DMA finishes first; dma_en dropped after acceptance.
        snap();
        dma_en      = 1'b1;
        cmd_trigger = 1'b1;
        tick();
        cmd_trigger = 1'b0;
        dma_en      = 1'b0;
        check("dmad_launch", 32'(outs()), 32'b11101);
        tick();
        dma_done = 1'b1;
        tick();
        dma_done = 1'b0;
        ticks(10);
        check("dmad_half_no_done", 32'(done_cnt - base_done), 32'd0);
        check("dmad_half_busy", 32'(busy), 32'd1);
        done_qspi = 1'b1;
        tick();
        done_qspi = 1'b0;
        check("dmad_done", 32'(outs()), 32'b00011);
        tick();
        check("dmad_idle", 32'(outs()), 32'b00000);

        // Simultaneous done pulses, plus a trigger while busy.
        snap();
        dma_en      = 1'b1;
        cmd_trigger = 1'b1;
        tick();
        cmd_trigger = 1'b0;
        tick();
        cmd_trigger = 1'b1;
        ticks(3);
        cmd_trigger = 1'b0;
        done_qspi   = 1'b1;
        dma_done    = 1'b1;
        tick();
        done_qspi   = 1'b0;
        dma_done    = 1'b0;
        check("sim_done", 32'(outs()), 32'b00011);
        tick();
        check("sim_idle", 32'(outs()), 32'b00000);
        check("sim_done_cnt", 32'(done_cnt - base_done), 32'd1);
        check("busy_trig_clear_cnt", 32'(clear_cnt - base_clear), 32'd1);
        check("busy_trig_start_cnt", 32'(start_cnt - base_start), 32'd1);

        // Done pulses in IDLE are ignored.
        snap();
        done_qspi = 1'b1;
        dma_done  = 1'b1;
        ticks(2);
        done_qspi = 1'b0;
        dma_done  = 1'b0;
        ticks(2);
        check("idle_done_ignored", 32'(done_cnt - base_done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);

        // A done asserted in the launch cycle is lost.
        snap();
        dma_en      = 1'b0;
        cmd_trigger = 1'b1;
        tick();
        cmd_trigger = 1'b0;
        done_qspi   = 1'b1;
        tick();
        done_qspi   = 1'b0;
        ticks(3);
        check("launch_done_lost_busy", 32'(busy), 32'd1);
        check("launch_done_lost_cnt", 32'(done_cnt - base_done), 32'd0);
        done_qspi = 1'b1;
        tick();
        done_qspi = 1'b0;
        check("launch_then_done", 32'(outs()), 32'b00011);
        tick();

        // Mid-command reset after the QSPI half has completed.
        snap();
        dma_en      = 1'b1;
        cmd_trigger = 1'b1;
        tick();
        cmd_trigger = 1'b0;
        tick();
        done_qspi = 1'b1;
        tick();
        done_qspi = 1'b0;
        rst       = 1'b1;
        tick();
        check("midrst_outs", 32'(outs()), 32'h0);
        rst      = 1'b0;
        dma_done = 1'b1;
        tick();
        dma_done = 1'b0;
        ticks(3);
        check("midrst_no_done", 32'(done_cnt - base_done), 32'd0);
        check("midrst_idle", 32'(outs()), 32'h0);

        // A fresh command after the abort completes normally.
        snap();
        dma_en      = 1'b0;
        cmd_trigger = 1'b1;
        tick();
        cmd_trigger = 1'b0;
        check("after_rst_launch", 32'(outs()), 32'b11001);
        ticks(2);
        done_qspi = 1'b1;
        tick();
        done_qspi = 1'b0;
        check("after_rst_done", 32'(outs()), 32'b00011);
        tick();
        check("after_rst_idle", 32'(outs()), 32'b00000);
        check("after_rst_done_cnt", 32'(done_cnt - base_done), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_ce
